// File: rtl/aircon_mode_ctrl_pkg.sv
// Purpose: shared mode encoding, thermo codes and ladder helpers for the aircon mode controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package aircon_mode_ctrl_pkg;

    // Linear ladder OFF -> LOW_FAN -> HIGH_FAN -> LOW_COOL -> HIGH_COOL.
    // Codes 5..7 are unreachable and are recovered to OFF by the controller.
    typedef enum logic [2:0] {
        MODE_OFF       = 3'd0,
        MODE_LOW_FAN   = 3'd1,
        MODE_HIGH_FAN  = 3'd2,
        MODE_LOW_COOL  = 3'd3,
        MODE_HIGH_COOL = 3'd4
    } mode_t;

    // One-hot bar-graph codes.
    localparam logic [3:0] THERMO_OFF       = 4'b0000;
    localparam logic [3:0] THERMO_LOW_FAN   = 4'b0001;
    localparam logic [3:0] THERMO_HIGH_FAN  = 4'b0010;
    localparam logic [3:0] THERMO_LOW_COOL  = 4'b0100;
    localparam logic [3:0] THERMO_HIGH_COOL = 4'b1000;

    function automatic logic [3:0] mode_thermo(input mode_t m);
        case (m)
            MODE_LOW_FAN:   return THERMO_LOW_FAN;
            MODE_HIGH_FAN:  return THERMO_HIGH_FAN;
            MODE_LOW_COOL:  return THERMO_LOW_COOL;
            MODE_HIGH_COOL: return THERMO_HIGH_COOL;
            default:        return THERMO_OFF;
        endcase
    endfunction

    // True when a step in the given direction would fall off the ladder.
    function automatic logic mode_at_limit(input mode_t m, input logic up);
        return up ? (m == MODE_HIGH_COOL) : (m == MODE_OFF);
    endfunction

    // One step along the ladder; callers check mode_at_limit first.
    function automatic mode_t mode_step(input mode_t m, input logic up);
        case (m)
            MODE_OFF:       return up ? MODE_LOW_FAN   : MODE_OFF;
            MODE_LOW_FAN:   return up ? MODE_HIGH_FAN  : MODE_OFF;
            MODE_HIGH_FAN:  return up ? MODE_LOW_COOL  : MODE_LOW_FAN;
            MODE_LOW_COOL:  return up ? MODE_HIGH_COOL : MODE_HIGH_FAN;
            MODE_HIGH_COOL: return up ? MODE_HIGH_COOL : MODE_LOW_COOL;
            default:        return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/aircon_mode_ctrl_timer.sv
// Purpose: loadable down-counter that saturates at zero, with a registered zero flag.
// Latency: load/tick take effect on the next rising edge of clk.
// Backpressure: none; load has priority over tick.
// Ports: clk, rst (sync, active-high), load + load_val, tick (decrement enable),
//        value (current count), zero (count == 0, registered).
module aircon_mode_ctrl_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            value <= load_val;
            zero  <= (load_val == '0);
        end else if (tick && !zero) begin
            value <= value - CNT_W'(1);
            zero  <= (value == CNT_W'(1));
        end
    end

endmodule

// File: rtl/aircon_mode_ctrl.sv
// Purpose: mode ladder FSM with dwell-time protection, 1-deep pending slot and auto-expiring turbo.
// Latency: input sampled at edge N shows on the registered outputs after edge N.
// Backpressure: none; requests during dwell are parked in a pending slot (newest wins).
// Ports: clk, rst (sync, active-high), up_in/down_in/turbo_in (1-cycle pulses),
//        thermo_out (one-hot mode), turbo_out, busy_out (dwell running), err_out (reject pulse).
module aircon_mode_ctrl
    import aircon_mode_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int TURBO_CYCLES = 5000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_in,
    input  logic       down_in,
    input  logic       turbo_in,
    output logic [3:0] thermo_out,
    output logic       turbo_out,
    output logic       busy_out,
    output logic       err_out
);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURBO_LOAD = CNT_W'(TURBO_CYCLES - 1);

    mode_t            state_q, state_n;
    logic             pend_vld_q, pend_vld_n;
    logic             pend_up_q, pend_up_n;
    logic             turbo_n, err_n;
    logic             dwell_load, turbo_load;
    logic [CNT_W-1:0] dwell_value, turbo_value;
    logic             dwell_zero, turbo_zero;
    logic             apply_vld, apply_up, pend_live, expiring;
    logic             unused_turbo_value;

    aircon_mode_ctrl_timer #(.CNT_W(CNT_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (dwell_load),
        .load_val (DWELL_LOAD),
        .tick     (1'b1),
        .value    (dwell_value),
        .zero     (dwell_zero)
    );

    aircon_mode_ctrl_timer #(.CNT_W(CNT_W)) u_turbo (
        .clk      (clk),
        .rst      (rst),
        .load     (turbo_load),
        .load_val (TURBO_LOAD),
        .tick     (1'b1),
        .value    (turbo_value),
        .zero     (turbo_zero)
    );

    // Turbo expiry only needs the zero flag.
    assign unused_turbo_value = ^turbo_value;

    assign busy_out = ~dwell_zero;
    // Edge on which the dwell counter steps 1 -> 0: pending work is released here.
    assign expiring = busy_out && (dwell_value == CNT_W'(1));

    always_comb begin
        state_n    = state_q;
        pend_vld_n = pend_vld_q;
        pend_up_n  = pend_up_q;
        turbo_n    = turbo_out;
        err_n      = 1'b0;
        dwell_load = 1'b0;
        turbo_load = 1'b0;
        apply_vld  = 1'b0;
        apply_up   = 1'b0;
        pend_live  = pend_vld_q;

        case (state_q)
            MODE_OFF, MODE_LOW_FAN, MODE_HIGH_FAN, MODE_LOW_COOL, MODE_HIGH_COOL: begin
                // Turbo rejection empties the slot as it stands this cycle; a mode
                // request arriving in the same cycle is still taken afterwards.
                if (turbo_in && state_q == MODE_OFF) begin
                    err_n      = 1'b1;
                    pend_live  = 1'b0;
                    pend_vld_n = 1'b0;
                end

                if (up_in && down_in) begin
                    err_n      = 1'b1;
                    pend_vld_n = 1'b0;
                end else if (up_in || down_in) begin
                    if (!busy_out || expiring) begin
                        // A fresh request on the expiry edge supersedes the slot.
                        apply_vld  = 1'b1;
                        apply_up   = up_in;
                        pend_vld_n = 1'b0;
                    end else begin
                        pend_vld_n = 1'b1;
                        pend_up_n  = up_in;
                    end
                end else if (expiring && pend_live) begin
                    apply_vld  = 1'b1;
                    apply_up   = pend_up_q;
                    pend_vld_n = 1'b0;
                end

                // Ladder limits are judged at application time, not at capture.
                if (apply_vld) begin
                    if (mode_at_limit(state_q, apply_up)) begin
                        err_n      = 1'b1;
                        pend_vld_n = 1'b0;
                    end else begin
                        state_n    = mode_step(state_q, apply_up);
                        dwell_load = 1'b1;
                    end
                end

                if (turbo_in && state_q != MODE_OFF) begin
                    turbo_n    = ~turbo_out;
                    turbo_load = ~turbo_out;
                end else if (turbo_out && turbo_zero) begin
                    turbo_n = 1'b0;
                end

                // Landing in OFF always drops turbo, even if toggled on this cycle.
                if (state_n == MODE_OFF) begin
                    turbo_n = 1'b0;
                end
            end
            default: begin
                state_n    = MODE_OFF;
                err_n      = 1'b1;
                turbo_n    = 1'b0;
                pend_vld_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MODE_OFF;
            pend_vld_q <= 1'b0;
            pend_up_q  <= 1'b0;
            thermo_out <= THERMO_OFF;
            turbo_out  <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            state_q    <= state_n;
            pend_vld_q <= pend_vld_n;
            pend_up_q  <= pend_up_n;
            thermo_out <= mode_thermo(state_n);
            turbo_out  <= turbo_n;
            err_out    <= err_n;
        end
    end

endmodule

// File: tb/tb_aircon_mode_ctrl.sv
// Purpose: self-checking bench for aircon_mode_ctrl (directed scenarios + randomized run vs model).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_aircon_mode_ctrl;

    localparam int DWELL = 4;
    localparam int TURBO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_in = 1'b0;
    logic       down_in = 1'b0;
    logic       turbo_in = 1'b0;
    logic [3:0] thermo_out;
    logic       turbo_out;
    logic       busy_out;
    logic       err_out;

    int errors = 0;
    int checks = 0;

    // Reference state: mode as ladder index 0..4, remaining dwell cycles,
    // pending request (-1 none, 0 down, 1 up), turbo flag and remaining turbo cycles.
    int m_mode = 0;
    int m_dwell = 0;
    int m_pend = -1;
    bit m_turbo = 0;
    int m_trem = 0;
    bit m_err = 0;

    aircon_mode_ctrl #(
        .DWELL_CYCLES (DWELL),
        .TURBO_CYCLES (TURBO),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_in      (up_in),
        .down_in    (down_in),
        .turbo_in   (turbo_in),
        .thermo_out (thermo_out),
        .turbo_out  (turbo_out),
        .busy_out   (busy_out),
        .err_out    (err_out)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_thermo();
        logic [3:0] one;
        one = 4'b0001;
        return (m_mode == 0) ? 4'b0000 : 4'(one << (m_mode - 1));
    endfunction

    task automatic model_step(input bit r, input bit u, input bit d, input bit t);
        int  next_mode, next_dwell, target, apply;
        bit  busy, exp_edge;
        if (r) begin
            m_mode = 0; m_dwell = 0; m_pend = -1; m_turbo = 0; m_trem = 0; m_err = 0;
            return;
        end
        busy       = (m_dwell > 0);
        exp_edge   = (m_dwell == 1);
        m_err      = 0;
        next_mode  = m_mode;
        next_dwell = busy ? m_dwell - 1 : 0;
        apply      = -1;
        if (t && m_mode == 0) begin
            m_err = 1; m_pend = -1;
        end
        if (u && d) begin
            m_err = 1; m_pend = -1;
        end else if (u || d) begin
            if (!busy || exp_edge) begin
                apply = u ? 1 : 0; m_pend = -1;
            end else begin
                m_pend = u ? 1 : 0;
            end
        end else if (exp_edge && m_pend >= 0) begin
            apply = m_pend; m_pend = -1;
        end
        if (apply >= 0) begin
            target = m_mode + ((apply == 1) ? 1 : -1);
            if (target < 0 || target > 4) begin
                m_err = 1; m_pend = -1;
            end else begin
                next_mode = target; next_dwell = DWELL - 1;
            end
        end
        if (t && m_mode != 0) begin
            if (m_turbo) m_turbo = 0;
            else begin
                m_turbo = 1; m_trem = TURBO - 1;
            end
        end else if (m_turbo) begin
            if (m_trem == 0) m_turbo = 0;
            else m_trem = m_trem - 1;
        end
        if (next_mode == 0) m_turbo = 0;
        m_mode  = next_mode;
        m_dwell = next_dwell;
    endtask

    // Drive one cycle of inputs, let the DUT sample them, then advance the model.
    task automatic tick(input bit r, input bit u, input bit d, input bit t);
        rst = r; up_in = u; down_in = d; turbo_in = t;
        @(posedge clk);
        #1;
        rst = 1'b0; up_in = 1'b0; down_in = 1'b0; turbo_in = 1'b0;
        model_step(r, u, d, t);
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0);
        checks++; if (thermo_out !== 4'b0000) begin errors++; $display("FAIL reset_thermo: got %b want 0000", thermo_out); end
        checks++; if (turbo_out !== 1'b0) begin errors++; $display("FAIL reset_turbo: got %b want 0", turbo_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_out); end
    endtask

    task automatic test_first_up();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        checks++; if (thermo_out !== 4'b0001) begin errors++; $display("FAIL first_up_thermo: got %b want 0001", thermo_out); end
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL first_up_busy1: got %b want 1", busy_out); end
        for (int i = 2; i <= 3; i++) begin
            tick(0, 0, 0, 0);
            checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL first_up_busy%0d: got %b want 1", i, busy_out); end
        end
        tick(0, 0, 0, 0);
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL first_up_busy_end: got %b want 0", busy_out); end
    endtask

    task automatic test_ladder();
        logic [3:0] want;
        tick(1, 0, 0, 0);
        want = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 0);
            checks++; if (thermo_out !== want) begin errors++; $display("FAIL ladder_step%0d: got %b want %b", i, thermo_out, want); end
            want = want << 1;
            repeat (4) tick(0, 0, 0, 0);
        end
        tick(0, 1, 0, 0);
        checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL ladder_top_err: got %b want 1", err_out); end
        checks++; if (thermo_out !== 4'b1000) begin errors++; $display("FAIL ladder_top_hold: got %b want 1000", thermo_out); end
        tick(0, 0, 0, 0);
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL ladder_err_pulse: got %b want 0", err_out); end
    endtask

    task automatic test_defer();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 1, 0);
        checks++; if (thermo_out !== 4'b0001) begin errors++; $display("FAIL defer_hold: got %b want 0001", thermo_out); end
        tick(0, 0, 0, 0);
        checks++; if (thermo_out !== 4'b0000) begin errors++; $display("FAIL defer_down_wins: got %b want 0000", thermo_out); end
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL defer_reload: got %b want 1", busy_out); end
        repeat (3) tick(0, 0, 0, 0);
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL defer_busy_end: got %b want 0", busy_out); end
    endtask

    task automatic test_turbo();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        repeat (4) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        repeat (4) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        checks++; if (turbo_out !== 1'b1) begin errors++; $display("FAIL turbo_on: got %b want 1", turbo_out); end
        for (int i = 2; i <= TURBO; i++) begin
            tick(0, 0, 0, 0);
            checks++; if (turbo_out !== 1'b1) begin errors++; $display("FAIL turbo_hold%0d: got %b want 1", i, turbo_out); end
        end
        tick(0, 0, 0, 0);
        checks++; if (turbo_out !== 1'b0) begin errors++; $display("FAIL turbo_expire: got %b want 0", turbo_out); end
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL turbo_off_err: got %b want 1", err_out); end
        checks++; if (turbo_out !== 1'b0) begin errors++; $display("FAIL turbo_off_flag: got %b want 0", turbo_out); end
        checks++; if (thermo_out !== 4'b0000) begin errors++; $display("FAIL turbo_off_mode: got %b want 0000", thermo_out); end
    endtask

    task automatic test_both_and_off();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        repeat (4) tick(0, 0, 0, 0);
        tick(0, 1, 1, 0);
        checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL both_err: got %b want 1", err_out); end
        checks++; if (thermo_out !== 4'b0001) begin errors++; $display("FAIL both_hold: got %b want 0001", thermo_out); end
        tick(0, 0, 0, 1);
        checks++; if (turbo_out !== 1'b1) begin errors++; $display("FAIL off_turbo_on: got %b want 1", turbo_out); end
        tick(0, 0, 1, 0);
        checks++; if (thermo_out !== 4'b0000) begin errors++; $display("FAIL off_mode: got %b want 0000", thermo_out); end
        checks++; if (turbo_out !== 1'b0) begin errors++; $display("FAIL off_turbo_clear: got %b want 0", turbo_out); end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 1);
        checks++; if (turbo_out !== 1'b1) begin errors++; $display("FAIL mid_turbo_on: got %b want 1", turbo_out); end
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL mid_busy_on: got %b want 1", busy_out); end
        tick(1, 0, 0, 0);
        checks++; if (thermo_out !== 4'b0000) begin errors++; $display("FAIL mid_rst_thermo: got %b want 0000", thermo_out); end
        checks++; if (turbo_out !== 1'b0) begin errors++; $display("FAIL mid_rst_turbo: got %b want 0", turbo_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy_out); end
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b want 0", err_out); end
    endtask

    task automatic test_random();
        bit r, u, d, t;
        tick(1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            u = ($urandom_range(0, 4) == 0);
            d = ($urandom_range(0, 5) == 0);
            t = ($urandom_range(0, 11) == 0);
            tick(r, u, d, t);
            checks++; if (thermo_out !== exp_thermo()) begin errors++; $display("FAIL rand_thermo cyc %0d: got %b want %b", n, thermo_out, exp_thermo()); end
            checks++; if (turbo_out !== m_turbo) begin errors++; $display("FAIL rand_turbo cyc %0d: got %b want %b", n, turbo_out, m_turbo); end
            checks++; if (busy_out !== (m_dwell > 0)) begin errors++; $display("FAIL rand_busy cyc %0d: got %b want %b", n, busy_out, (m_dwell > 0)); end
            checks++; if (err_out !== m_err) begin errors++; $display("FAIL rand_err cyc %0d: got %b want %b", n, err_out, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_first_up();
        test_ladder();
        test_defer();
        test_turbo();
        test_both_and_off();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
